sliding_ring_buffer: RTL and testbench
======================================

# sliding_ring_buffer

Parametrised ring buffer with multi-word write and sliding-window read. Each cycle the producer writes a variable number of words, 1..WRITE_SIZE. The consumer sees READ_SIZE consecutive words starting at the read pointer and retires a variable stride, 0..READ_SIZE, so overlapping windows are supported. It sits between the input loader and the convolution datapath and replaces the fixed-stride buffer with real full/empty handshaking, an occupancy level and a flush.

## Interface
- SIZE, 16, storage depth in words; power of two, ≥ 2·max(WRITE_SIZE, READ_SIZE)
- WRITE_SIZE, 2, max words written per cycle
- READ_SIZE, 3, window width in words
- DATA_WIDTH, 8, bits per word
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of pointers and level
- wr_valid  in  1  write request
- wr_num  in  $clog2(WRITE_SIZE+1)  words to write this cycle
- in  in  DATA_WIDTH×WRITE_SIZE  write words; in[0] is the oldest
- wr_ready  out  1  buffer can accept WRITE_SIZE words
- rd_pop  in  1  retire request
- rd_stride  in  $clog2(READ_SIZE+1)  words to retire
- out  out  DATA_WIDTH×READ_SIZE  window; out[k] = mem[(rd_ptr+k) mod SIZE]
- out_valid  out  1  level ≥ READ_SIZE
- level  out  $clog2(SIZE+1)  words currently stored
- err  out  1  sticky protocol error (see Configuration)

## Operation
- State: mem[SIZE], wr_ptr and rd_ptr ($clog2(SIZE) bits, wrap modulo SIZE), level.
- wr_ready = (SIZE − level) ≥ WRITE_SIZE. This is deliberately independent of wr_num, so there is no combinational path from wr_num.
- Write accept = wr_valid & wr_ready. For k < wr_num: mem[(wr_ptr+k) mod SIZE] ← in[k]. Then wr_ptr += wr_num.
- wr_num > WRITE_SIZE is clamped to WRITE_SIZE. wr_num = 0 accepts nothing.
- Pop accept = rd_pop & out_valid. rd_ptr += rd_stride.
- rd_stride > READ_SIZE is clamped to READ_SIZE. rd_pop while !out_valid is ignored.
- level_next = level + accepted wr_num − accepted stride. Simultaneous write and pop are always legal.
- The window is read from registered storage, with no write-through. A word written in the same cycle is not visible on out until after the edge.
- Wrap: window and write indices wrap modulo SIZE with no gap. Pointers wrap silently.
- flush has priority over write and pop: wr_ptr, rd_ptr and level go to 0, err clears, and mem is untouched.

## Timing
- Reset (rst low, asynchronous):
  - pointers, level = 0
  - mem cleared to 0, so out = all zeros
  - out_valid = 0, wr_ready = 1, err = 0
- Reset deasserted mid-operation: the buffer restarts empty, and any in-flight write is lost.
- Write latency: data accepted at edge N is reflected in level, out_valid and out during cycle N+1.
- Pop latency: rd_ptr advances at the edge, and the new window appears in the next cycle.
- out, out_valid, wr_ready and level are all decoded from registers only; none depends combinationally on any input.
- Full boundary: level > SIZE − WRITE_SIZE forces wr_ready = 0, even if wr_num would fit.
- Empty boundary: level < READ_SIZE forces out_valid = 0.

## Configuration
- SLIDING_RING_BUFFER_ERR_EN
  - Defined: err sets and stays set (until rst or flush) on any of:
    - wr_valid & !wr_ready
    - wr_valid & (wr_num = 0 or wr_num > WRITE_SIZE)
    - rd_pop & !out_valid
    - rd_pop & rd_stride > READ_SIZE
  - Not defined: err is tied 0 and no error logic is built. Clamp and ignore behaviour is identical in both builds.

## Structure
- Package sliding_ring_buffer_pkg holds:
  - width helper functions: PTR_W = $clog2(SIZE), LVL_W = $clog2(SIZE+1), wr/rd count widths
  - a clamp function for wr_num and rd_stride
- Sub-module ring_addr: combinational (base + offset) mod SIZE. It is instantiated once per write lane and once per window lane.

## Test plan
- Reset → out = {0,0,0}, level = 0, out_valid = 0, wr_ready = 1.
- Writes (wr_num = 2) of {1,2}, {3,4} → level = 4, out = {1,2,3}. Pop with stride 1 → out = {2,3,4}, level = 3.
- Fill to level 15 (SIZE 16) → wr_ready = 0. A write attempted in that state does not change level and, in an ERR_EN build, sets err.
- Wrap: keep the pointers wrapping past index 15 with writes of 2 and pops of stride 2 for 40 cycles → out always equals the reference-model sequence, and level stays constant.
- Simultaneous write of 2 and pop of 3 at level 5 → level = 4. Flush asserted together with a write → level = 0 and the write is dropped.
- Assert rst low mid-write → outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sliding_ring_buffer_pkg.sv
// rtl/sliding_ring_buffer_pkg.sv - width and clamp helpers for the sliding ring buffer
//
// Purpose: shared helper functions used by sliding_ring_buffer and its
//          address sub-module.
//   ptr_width  : pointer width for a storage depth, $clog2(size)
//   lvl_width  : occupancy width able to hold 0..size, $clog2(size+1)
//   cnt_width  : width of a count field holding 0..max_cnt
//   clamp_cnt  : saturate a requested count to its maximum
// No ports (package).

package sliding_ring_buffer_pkg;

   function automatic int ptr_width(input int size);
      return $clog2(size);
   endfunction

   function automatic int lvl_width(input int size);
      return $clog2(size + 1);
   endfunction

   function automatic int cnt_width(input int max_cnt);
      return $clog2(max_cnt + 1);
   endfunction

   // Oversized requests are saturated, never rejected.
   function automatic int clamp_cnt(input int cnt, input int max_cnt);
      return (cnt > max_cnt) ? max_cnt : cnt;
   endfunction

endpackage

// File: rtl/sliding_ring_buffer_ring_addr.sv
// rtl/sliding_ring_buffer_ring_addr.sv - modulo-SIZE address adder for one buffer lane
//
// Purpose: addr = (base + offset) mod SIZE, purely combinational.
// Ports:
//   base   in  ptr_width(SIZE)  lane base pointer (wr_ptr or rd_ptr)
//   offset in  ptr_width(SIZE)  lane index within the write group / window
//   addr   out ptr_width(SIZE)  wrapped storage index
// SIZE is a power of two, so the modulo is the natural overflow of the adder.

module sliding_ring_buffer_ring_addr
   import sliding_ring_buffer_pkg::*;
#(
   parameter int SIZE = 16
) (
   input  logic [ptr_width(SIZE)-1:0] base,
   input  logic [ptr_width(SIZE)-1:0] offset,
   output logic [ptr_width(SIZE)-1:0] addr
);

   assign addr = base + offset;

endmodule

// File: rtl/sliding_ring_buffer.sv
// rtl/sliding_ring_buffer.sv - ring buffer with multi-word write and sliding-window read
//
// Purpose: producer writes 1..WRITE_SIZE words per cycle; consumer sees a
//          READ_SIZE-word window at rd_ptr and retires 0..READ_SIZE words.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset (clears storage too)
//   flush      in   synchronous clear of pointers, level and err
//   wr_valid   in   write request
//   wr_num     in   words to write (clamped to WRITE_SIZE)
//   in         in   write words, word 0 in the low bits is the oldest
//   wr_ready   out  room for a full WRITE_SIZE group
//   rd_pop     in   retire request
//   rd_stride  in   words to retire (clamped to READ_SIZE)
//   out        out  window, word k = mem[(rd_ptr+k) mod SIZE], word 0 in low bits
//   out_valid  out  level >= READ_SIZE
//   level      out  words stored
//   err        out  sticky protocol error
// Optional feature macro: SLIDING_RING_BUFFER_ERR_EN builds the err logic;
// without it err is tied low. Clamp/ignore behaviour is the same either way.

module sliding_ring_buffer
   import sliding_ring_buffer_pkg::*;
#(
   parameter int SIZE       = 16,
   parameter int WRITE_SIZE = 2,
   parameter int READ_SIZE  = 3,
   parameter int DATA_WIDTH = 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 flush,
   input  logic                                 wr_valid,
   input  logic [cnt_width(WRITE_SIZE)-1:0]     wr_num,
   input  logic [DATA_WIDTH*WRITE_SIZE-1:0]     in,
   output logic                                 wr_ready,
   input  logic                                 rd_pop,
   input  logic [cnt_width(READ_SIZE)-1:0]      rd_stride,
   output logic [DATA_WIDTH*READ_SIZE-1:0]      out,
   output logic                                 out_valid,
   output logic [lvl_width(SIZE)-1:0]           level,
   output logic                                 err
);

   localparam int PTR_W = ptr_width(SIZE);
   localparam int LVL_W = lvl_width(SIZE);
   localparam int WR_W  = cnt_width(WRITE_SIZE);
   localparam int RD_W  = cnt_width(READ_SIZE);

   logic [DATA_WIDTH-1:0] mem [SIZE];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_addr [WRITE_SIZE];
   logic [PTR_W-1:0]      rd_addr [READ_SIZE];

   logic                  wr_acc;
   logic                  pop_acc;
   logic [WR_W-1:0]       wr_cnt;
   logic [RD_W-1:0]       rd_cnt;

   // Handshake flags decode from level only, so there is no combinational
   // path from wr_num/rd_stride to wr_ready/out_valid.
   assign wr_ready  = (level <= LVL_W'(SIZE - WRITE_SIZE));
   assign out_valid = (level >= LVL_W'(READ_SIZE));

   assign wr_acc  = wr_valid & wr_ready;
   assign pop_acc = rd_pop & out_valid;

   // Accepted counts after clamping; zero when the request is not accepted.
   assign wr_cnt = wr_acc  ? WR_W'(clamp_cnt(int'(wr_num), WRITE_SIZE))   : '0;
   assign rd_cnt = pop_acc ? RD_W'(clamp_cnt(int'(rd_stride), READ_SIZE)) : '0;

   for (genvar k = 0; k < WRITE_SIZE; k++) begin : g_wr_lane
      sliding_ring_buffer_ring_addr #(.SIZE(SIZE)) u_ring_addr (
         .base   (wr_ptr),
         .offset (PTR_W'(k)),
         .addr   (wr_addr[k])
      );
   end

   // Window is read straight from storage: a word written this cycle only
   // shows up on out after the edge.
   for (genvar k = 0; k < READ_SIZE; k++) begin : g_rd_lane
      sliding_ring_buffer_ring_addr #(.SIZE(SIZE)) u_ring_addr (
         .base   (rd_ptr),
         .offset (PTR_W'(k)),
         .addr   (rd_addr[k])
      );
      assign out[k*DATA_WIDTH +: DATA_WIDTH] = mem[rd_addr[k]];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         for (int i = 0; i < SIZE; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         // Storage is deliberately left alone; only the bookkeeping resets.
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         for (int k = 0; k < WRITE_SIZE; k++) begin
            if (k < int'(wr_cnt)) begin
               mem[wr_addr[k]] <= in[k*DATA_WIDTH +: DATA_WIDTH];
            end
         end
         wr_ptr <= wr_ptr + PTR_W'(wr_cnt);
         rd_ptr <= rd_ptr + PTR_W'(rd_cnt);
         level  <= level + LVL_W'(wr_cnt) - LVL_W'(rd_cnt);
      end
   end

`ifdef SLIDING_RING_BUFFER_ERR_EN
   logic err_q;
   logic err_set;

   assign err_set = (wr_valid & ~wr_ready)
                  | (wr_valid & ((wr_num == '0) | (int'(wr_num) > WRITE_SIZE)))
                  | (rd_pop & ~out_valid)
                  | (rd_pop & (int'(rd_stride) > READ_SIZE));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else if (flush) begin
         err_q <= 1'b0;
      end else if (err_set) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sliding_ring_buffer.sv
// tb/tb_sliding_ring_buffer.sv - directed self-checking bench for sliding_ring_buffer

module tb_sliding_ring_buffer;

`ifdef SLIDING_RING_BUFFER_ERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        wr_valid;
   logic [1:0]  wr_num;
   logic [15:0] din;
   logic        wr_ready;
   logic        rd_pop;
   logic [1:0]  rd_stride;
   logic [23:0] dout;
   logic        out_valid;
   logic [4:0]  level;
   logic        err;

   int n_vec = 0;
   int n_bad = 0;

   logic [7:0] q [$];
   logic [7:0] nxt;

   sliding_ring_buffer #(
      .SIZE(16), .WRITE_SIZE(2), .READ_SIZE(3), .DATA_WIDTH(8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .wr_valid  (wr_valid),
      .wr_num    (wr_num),
      .in        (din),
      .wr_ready  (wr_ready),
      .rd_pop    (rd_pop),
      .rd_stride (rd_stride),
      .out       (dout),
      .out_valid (out_valid),
      .level     (level),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush = 0; wr_valid = 0; wr_num = 0; din = 0; rd_pop = 0; rd_stride = 0;
   endtask

   initial begin
      idle();
      rst = 1;
      #2 rst = 0;
      step();
      check("reset_out", 32'(dout), 32'h0);
      check("reset_level", 32'(level), 32'd0);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_wr_ready", 32'(wr_ready), 32'd1);
      check("reset_err", 32'(err), 32'd0);
      rst = 1;
      step();

      // two writes of two words
      wr_valid = 1; wr_num = 2; din = {8'd2, 8'd1};
      step();
      din = {8'd4, 8'd3};
      step();
      idle();
      check("wr_level", 32'(level), 32'd4);
      check("wr_out", 32'(dout), 32'h030201);
      check("wr_out_valid", 32'(out_valid), 32'd1);

      rd_pop = 1; rd_stride = 1;
      step();
      idle();
      check("pop1_out", 32'(dout), 32'h040302);
      check("pop1_level", 32'(level), 32'd3);

      // fill to 15 words (values 5..16 at indices 4..15)
      for (int i = 0; i < 6; i++) begin
         wr_valid = 1; wr_num = 2;
         din = {8'(6 + 2*i), 8'(5 + 2*i)};
         step();
      end
      idle();
      check("full_level", 32'(level), 32'd15);
      check("full_wr_ready", 32'(wr_ready), 32'd0);
      wr_valid = 1; wr_num = 1; din = 16'h00EE;
      step();
      idle();
      check("full_write_level", 32'(level), 32'd15);
      check("full_write_err", 32'(err), 32'(ERR_EN));

      // flush beats a concurrent write; storage untouched
      flush = 1; wr_valid = 1; wr_num = 2; din = {8'hBB, 8'hAA};
      step();
      idle();
      check("flush_level", 32'(level), 32'd0);
      check("flush_out_valid", 32'(out_valid), 32'd0);
      check("flush_wr_ready", 32'(wr_ready), 32'd1);
      check("flush_err", 32'(err), 32'd0);
      check("flush_out_mem", 32'(dout), 32'h030201);

      // pop while empty is ignored
      rd_pop = 1; rd_stride = 2;
      step();
      idle();
      check("empty_pop_level", 32'(level), 32'd0);
      check("empty_pop_err", 32'(err), 32'(ERR_EN));
      flush = 1;
      step();
      idle();
      check("reflush_err", 32'(err), 32'd0);

      // oversized wr_num clamps to two words
      wr_valid = 1; wr_num = 3; din = {8'h11, 8'h10};
      step();
      idle();
      check("clamp_level", 32'(level), 32'd2);
      check("clamp_err", 32'(err), 32'(ERR_EN));
      wr_valid = 1; wr_num = 2; din = {8'h13, 8'h12};
      step();
      wr_num = 1; din = {8'hFF, 8'h14};
      step();
      idle();
      check("lvl5_level", 32'(level), 32'd5);
      check("lvl5_out", 32'(dout), 32'h121110);

      // simultaneous write 2 / pop 3 at level 5
      wr_valid = 1; wr_num = 2; din = {8'h16, 8'h15};
      rd_pop = 1; rd_stride = 3;
      step();
      idle();
      check("simul_level", 32'(level), 32'd4);
      check("simul_out", 32'(dout), 32'h151413);

      // wrap: steady write-2 / pop-2 against a queue model
      flush = 1;
      step();
      idle();
      wr_valid = 1; wr_num = 2; din = {8'h41, 8'h40};
      step();
      din = {8'h43, 8'h42};
      step();
      idle();
      q.delete();
      for (int i = 0; i < 4; i++) q.push_back(8'(8'h40 + i));
      nxt = 8'h44;
      for (int c = 0; c < 40; c++) begin
         check("wrap_out", 32'(dout), 32'({q[2], q[1], q[0]}));
         check("wrap_level", 32'(level), 32'd4);
         wr_valid = 1; wr_num = 2; din = {nxt + 8'd1, nxt};
         rd_pop = 1; rd_stride = 2;
         step();
         q.push_back(nxt);
         q.push_back(nxt + 8'd1);
         void'(q.pop_front());
         void'(q.pop_front());
         nxt = nxt + 8'd2;
      end
      idle();
      check("wrap_final_out", 32'(dout), 32'({q[2], q[1], q[0]}));
      check("wrap_final_level", 32'(level), 32'd4);

      // asynchronous reset in the middle of a write cycle
      wr_valid = 1; wr_num = 2; din = {8'h77, 8'h66};
      #3 rst = 0;
      #1;
      check("async_rst_level", 32'(level), 32'd0);
      check("async_rst_out", 32'(dout), 32'h0);
      check("async_rst_out_valid", 32'(out_valid), 32'd0);
      check("async_rst_wr_ready", 32'(wr_ready), 32'd1);
      step();
      idle();
      rst = 1;
      step();
      check("post_rst_level", 32'(level), 32'd0);
      check("post_rst_out", 32'(dout), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
